// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the core/RAM side.
interface riscv_mem_arbiter_if #(
    parameter int MEM_WORDS_LOG2 = 12
);
    logic [31:0]               i_address;
    logic [31:0]               i_data;
    logic                      i_valid;
    logic                      core_wait;
    logic [31:0]               d_address;
    logic [1:0]                d_width;
    logic [31:0]               d_wdata;
    logic                      d_read;
    logic                      d_write;
    logic [31:0]               d_rdata;
    logic [MEM_WORDS_LOG2-1:0] mem_address;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_be;
    logic                      mem_write;
    logic [31:0]               mem_rdata;

    modport slave (
        input  i_address, d_address, d_width, d_wdata, d_read, d_write, mem_rdata,
        output i_data, i_valid, core_wait, d_rdata, mem_address, mem_wdata, mem_be, mem_write
    );

    modport master (
        output i_address, d_address, d_width, d_wdata, d_read, d_write, mem_rdata,
        input  i_data, i_valid, core_wait, d_rdata, mem_address, mem_wdata, mem_be, mem_write
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access, data first.
// Define RISCV_MEM_ARB_ALIGN_CHECK_EN to trap misaligned data accesses (adds err_misaligned).
module riscv_mem_arbiter #(
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic               clock,
    input  logic               reset,
`ifdef RISCV_MEM_ARB_ALIGN_CHECK_EN
    output logic               err_misaligned,
`endif
    riscv_mem_arbiter_if.slave bus
);

    typedef enum logic {FETCH, DEFER} state_e;
    typedef enum logic [1:0] {RSP_NONE, RSP_FETCH, RSP_LOAD} rsp_e;

    state_e      state_q, state_d;
    rsp_e        rspSel_q, rspSel_d;
    logic [1:0]  offset_q;
    logic        zeroLoad_q;
    logic [31:0] iHold_q, dHold_q;

    logic        dataReq, dataGrant, misaligned, storeGrant;
    logic [1:0]  effWidth, effOffset;
    logic        unusedBits;

    assign unusedBits = ^{bus.i_address[31:MEM_WORDS_LOG2+2], bus.i_address[1:0],
                          bus.d_address[31:MEM_WORDS_LOG2+2]};

    // Width 3 acts as a word; offset bits below the access size are dropped, or trapped when checking.
    always_comb begin
        dataReq  = bus.d_read | bus.d_write;
        effWidth = (bus.d_width == 2'd3) ? 2'd2 : bus.d_width;
        case (effWidth)
            2'd0:    effOffset = bus.d_address[1:0];
            2'd1:    effOffset = {bus.d_address[1], 1'b0};
            default: effOffset = 2'b00;
        endcase
`ifdef RISCV_MEM_ARB_ALIGN_CHECK_EN
        misaligned = dataReq && ((effOffset != bus.d_address[1:0]) || (bus.d_width == 2'd3));
`else
        misaligned = 1'b0;
`endif
        dataGrant  = dataReq && !misaligned;
        storeGrant = dataGrant && bus.d_write;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (dataGrant)  state_d = DEFER;
            DEFER: if (!dataGrant) state_d = FETCH;
        endcase
    end

    always_comb begin
        bus.core_wait   = dataGrant;
        bus.mem_address = dataGrant ? bus.d_address[MEM_WORDS_LOG2+1:2]
                                    : bus.i_address[MEM_WORDS_LOG2+1:2];
        bus.mem_write   = storeGrant;
        bus.mem_be      = 4'b0000;
        bus.mem_wdata   = bus.d_wdata;
        case (effWidth)
            2'd0:    bus.mem_wdata = {4{bus.d_wdata[7:0]}};
            2'd1:    bus.mem_wdata = {2{bus.d_wdata[15:0]}};
            default: bus.mem_wdata = bus.d_wdata;
        endcase
        if (storeGrant) begin
            case (effWidth)
                2'd0:    bus.mem_be = 4'b0001 << effOffset;
                2'd1:    bus.mem_be = 4'b0011 << effOffset;
                default: bus.mem_be = 4'b1111;
            endcase
        end
        rspSel_d = RSP_FETCH;
        if (dataGrant) begin
            rspSel_d = bus.d_write ? RSP_NONE : RSP_LOAD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rspSel_q   <= RSP_NONE;
            offset_q   <= 2'b00;
            zeroLoad_q <= 1'b0;
            iHold_q    <= 32'h0;
            dHold_q    <= 32'h0;
        end else begin
            rspSel_q   <= rspSel_d;
            offset_q   <= effOffset;
            zeroLoad_q <= misaligned;
            iHold_q    <= bus.i_data;
            dHold_q    <= bus.d_rdata;
        end
    end

    // RAM data is only meaningful the cycle after its owner was granted; otherwise replay the held value.
    always_comb begin
        bus.i_valid = (rspSel_q == RSP_FETCH);
        bus.i_data  = (rspSel_q == RSP_FETCH) ? bus.mem_rdata : iHold_q;
        bus.d_rdata = dHold_q;
        if (zeroLoad_q) begin
            bus.d_rdata = 32'h0;
        end else if (rspSel_q == RSP_LOAD) begin
            bus.d_rdata = bus.mem_rdata >> {offset_q, 3'b000};
        end
    end

`ifdef RISCV_MEM_ARB_ALIGN_CHECK_EN
    logic errMisaligned_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            errMisaligned_q <= 1'b0;
        end else if (misaligned) begin
            errMisaligned_q <= 1'b1;
        end
    end

    assign err_misaligned = errMisaligned_q;
`endif

endmodule
